frame_pixel_source: RTL and testbench
=====================================

FRAME_PIXEL_SOURCE -- requirements
Module: frame_pixel_source

Interface
REQ-001 Parameter H_RES, default 160, active pixels per line.
REQ-002 Parameter V_RES, default 120, active lines per frame.
REQ-003 Parameter ADDR_WIDTH, default 15, frame-buffer address width; H_RES*V_RES SHALL be <= 2^ADDR_WIDTH.
REQ-004 Parameters BOX_X0/BOX_X1/BOX_Y0/BOX_Y1, defaults 41/118/31/88, inclusive box window.
REQ-005 Parameter CHECK_LOG2, default 3, checker square edge = 2^CHECK_LOG2 pixels.
REQ-006 clk_25  input  1  single system clock; all logic on its rising edge.
REQ-007 reset_n  input  1  reset, asynchronous, active-low.
REQ-008 enable  input  1  level; permits frames to start.
REQ-009 mode  input  2  0 solid, 1 box, 2 checker, 3 camera threshold.
REQ-010 threshold  input  8  luma compare level for mode 3.
REQ-011 y_valid  input  1  luma sample strobe, already in clk_25 domain.
REQ-012 y_in  input  8  luma sample, qualified by y_valid.
REQ-013 we  output  1  frame-buffer write enable.
REQ-014 write_addr  output  ADDR_WIDTH  frame-buffer write address.
REQ-015 pixel  output  1  1 = white, 0 = black.
REQ-016 frame_done  output  1  one-cycle pulse on last pixel write of a frame.
REQ-017 busy  output  1  high while a frame is in progress.

Function
REQ-018 FSM states IDLE, RUN; IDLE->RUN when enable=1; RUN->IDLE after pixel (H_RES-1, V_RES-1) is issued if enable=0, else stays RUN and restarts at (0,0).
REQ-019 mode SHALL be latched on IDLE->RUN and at each frame restart; changes mid-frame ignored.
REQ-020 Advance event: every cycle in RUN for latched modes 0-2; only cycles with y_valid=1 in mode 3.
REQ-021 Internal h counter 0..H_RES-1, v counter 0..V_RES-1; h wraps to 0 and v increments on h=H_RES-1; v wraps to 0 after V_RES-1.
REQ-022 Address counter increments by 1 per advance event, equals v*H_RES+h, returns to 0 at frame restart; no multiplier.
REQ-023 Outputs registered: we=1, write_addr, pixel valid the cycle after the advance event (latency 1); we=0 on all other cycles.
REQ-024 Mode 0: pixel=1. Mode 1: pixel=0 when BOX_X0<=h<=BOX_X1 and BOX_Y0<=v<=BOX_Y1, else 1.
REQ-025 Mode 2: pixel = ~(h[CHECK_LOG2] ^ v[CHECK_LOG2]); square at (0,0) white.
REQ-026 Mode 3: pixel = (y_in >= threshold), unsigned 8-bit compare; threshold sampled with y_in.
REQ-027 frame_done asserted in the same cycle as we for address H_RES*V_RES-1, exactly one cycle.
REQ-028 enable deasserted mid-frame SHALL NOT abort; frame completes, then IDLE.
REQ-029 busy=1 in RUN, 0 in IDLE, registered.
REQ-030 Mode 3 with y_valid held low: counters, address and outputs hold; we=0.

Reset
REQ-031 reset_n=0 asynchronously forces state IDLE, counters 0, address 0, we=0, pixel=0, write_addr=0, frame_done=0, busy=0, latched mode 0.
REQ-032 Reset asserted mid-frame SHALL discard the partial frame; after release, next frame starts at address 0.

Verification
REQ-033 Default params, mode=1, enable=1 one frame -> 19200 writes, addresses 0..19199 consecutive, pixel=0 at addr 41 of line 31 (addr 5001), pixel=1 at addr 40 (4960+40), frame_done only with addr 19199.
REQ-034 mode=2, CHECK_LOG2=3 -> pixel at (0,0)=1, (8,0)=0, (8,8)=1, (7,15)=0.
REQ-035 mode=3, threshold=0x80, y_valid every 3rd cycle, y_in alternating 0x7F/0x80 -> we only after strobes, pixel 0/1 alternating, addresses consecutive.
REQ-036 mode switched 1->2 mid-frame -> remainder of frame is box pattern; next frame checker.
REQ-037 enable dropped at addr 100 -> writes continue to 19199, frame_done pulses, busy falls next cycle, no further we.
REQ-038 reset_n pulsed low at addr 5000 -> all outputs 0 immediately; after release with enable=1, first write addr 0.

Source files
------------

// File: rtl/frame_pixel_source.sv
// frame_pixel_source: raster-scans an H_RES x V_RES frame buffer and writes
// one 1-bit pixel per advance event. The pattern is solid white, a black box,
// a checkerboard, or a thresholded camera luma stream. Outputs are registered
// and appear one cycle after the pixel is issued.
module frame_pixel_source #(
    parameter int H_RES      = 160,
    parameter int V_RES      = 120,
    parameter int ADDR_WIDTH = 15,
    parameter int BOX_X0     = 41,
    parameter int BOX_X1     = 118,
    parameter int BOX_Y0     = 31,
    parameter int BOX_Y1     = 88,
    parameter int CHECK_LOG2 = 3
) (
    input  logic                  clk_25,
    input  logic                  reset_n,
    input  logic                  enable,
    input  logic [1:0]            mode,
    input  logic [7:0]            threshold,
    input  logic                  y_valid,
    input  logic [7:0]            y_in,
    output logic                  we,
    output logic [ADDR_WIDTH-1:0] write_addr,
    output logic                  pixel,
    output logic                  frame_done,
    output logic                  busy
);

    localparam int HW = (H_RES > 1) ? $clog2(H_RES) : 1;
    localparam int VW = (V_RES > 1) ? $clog2(V_RES) : 1;
    localparam logic [HW-1:0] H_LAST = HW'(H_RES - 1);
    localparam logic [VW-1:0] V_LAST = VW'(V_RES - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t                  state, state_nx;
    logic [1:0]              mode_q;
    logic [HW-1:0]           h_cnt;
    logic [VW-1:0]           v_cnt;
    logic [ADDR_WIDTH-1:0]   addr_cnt;
    logic                    advance;
    logic                    load_mode;
    logic                    last_pix;
    logic                    in_box;
    logic                    pix_nx;

    assign last_pix = (h_cnt == H_LAST) && (v_cnt == V_LAST);

    assign in_box = (int'(h_cnt) >= BOX_X0) && (int'(h_cnt) <= BOX_X1) &&
                    (int'(v_cnt) >= BOX_Y0) && (int'(v_cnt) <= BOX_Y1);

    // Pattern for the pixel currently addressed by the counters
    always_comb begin
        pix_nx = 1'b1;
        case (mode_q)
            2'd0:    pix_nx = 1'b1;
            2'd1:    pix_nx = ~in_box;
            2'd2:    pix_nx = ~(h_cnt[CHECK_LOG2] ^ v_cnt[CHECK_LOG2]);
            default: pix_nx = (y_in >= threshold);
        endcase
    end

    // State register
    always_ff @(posedge clk_25 or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    // Next state, advance qualification and mode-latch strobe
    always_comb begin
        state_nx  = state;
        advance   = 1'b0;
        load_mode = 1'b0;
        case (state)
            IDLE: begin
                if (enable) begin
                    state_nx  = RUN;
                    load_mode = 1'b1;
                end
            end
            RUN: begin
                // camera mode only moves on a luma strobe
                advance = (mode_q != 2'd3) || y_valid;
                if (advance && last_pix) begin
                    if (enable) load_mode = 1'b1;
                    else        state_nx  = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Mode is only sampled at frame boundaries so a frame never mixes patterns
    always_ff @(posedge clk_25 or negedge reset_n) begin
        if (!reset_n)       mode_q <= 2'd0;
        else if (load_mode) mode_q <= mode;
    end

    // Raster counters; the linear address tracks v*H_RES+h by incrementing
    always_ff @(posedge clk_25 or negedge reset_n) begin
        if (!reset_n) begin
            h_cnt    <= '0;
            v_cnt    <= '0;
            addr_cnt <= '0;
        end else if (advance) begin
            if (last_pix) begin
                h_cnt    <= '0;
                v_cnt    <= '0;
                addr_cnt <= '0;
            end else begin
                addr_cnt <= addr_cnt + 1'b1;
                if (h_cnt == H_LAST) begin
                    h_cnt <= '0;
                    v_cnt <= v_cnt + 1'b1;
                end else begin
                    h_cnt <= h_cnt + 1'b1;
                end
            end
        end
    end

    // Registered write port; address and pixel hold between advance events
    always_ff @(posedge clk_25 or negedge reset_n) begin
        if (!reset_n) begin
            we         <= 1'b0;
            write_addr <= '0;
            pixel      <= 1'b0;
            frame_done <= 1'b0;
            busy       <= 1'b0;
        end else begin
            we         <= advance;
            frame_done <= advance && last_pix;
            busy       <= (state == RUN);
            if (advance) begin
                write_addr <= addr_cnt;
                pixel      <= pix_nx;
            end
        end
    end

endmodule

// File: tb/tb_frame_pixel_source.sv
// Directed bench for frame_pixel_source at default parameters.
module tb_frame_pixel_source;

    localparam int H    = 160;
    localparam int V    = 120;
    localparam int AW   = 15;
    localparam int NPIX = H * V;

    logic          clk_25 = 1'b0;
    logic          reset_n;
    logic          enable;
    logic [1:0]    mode;
    logic [7:0]    threshold;
    logic          y_valid;
    logic [7:0]    y_in;
    logic          we;
    logic [AW-1:0] write_addr;
    logic          pixel;
    logic          frame_done;
    logic          busy;

    int vectors     = 0;
    int miscompares = 0;

    always #20 clk_25 = ~clk_25;

    frame_pixel_source dut (
        .clk_25     (clk_25),
        .reset_n    (reset_n),
        .enable     (enable),
        .mode       (mode),
        .threshold  (threshold),
        .y_valid    (y_valid),
        .y_in       (y_in),
        .we         (we),
        .write_addr (write_addr),
        .pixel      (pixel),
        .frame_done (frame_done),
        .busy       (busy)
    );

    task automatic test_reset();
        reset_n = 1'b0; enable = 1'b0; mode = 2'd0;
        threshold = 8'h00; y_valid = 1'b0; y_in = 8'h00;
        #5;
        vectors++;
        if (we !== 1'b0 || frame_done !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_ctl: we=%b fd=%b busy=%b, required 0 0 0", we, frame_done, busy);
        end
        vectors++;
        if (write_addr !== '0 || pixel !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_data: addr=%0d pixel=%b, required 0 0", write_addr, pixel);
        end
        repeat (2) @(negedge clk_25);
        reset_n = 1'b1;
        repeat (3) @(negedge clk_25);
        vectors++;
        if (we !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_after_reset: we=%b busy=%b, required 0 0", we, busy);
        end
    endtask

    // Box frame, enable dropped at address 100: frame must still complete
    task automatic test_box_frame();
        int exp_a = 0;
        bit ok = 0;
        int pa[6] = '{0, 4960 + 40, 5001, 14198, 14199, 14281};
        bit pv[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        mode = 2'd1; enable = 1'b1;
        for (int c = 0; c < 10 && !ok; c++) begin
            @(negedge clk_25);
            ok = (we === 1'b1);
        end
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL box_start: we=%b, required 1 within 10 cycles", we);
            return;
        end
        while (exp_a < NPIX) begin
            vectors++;
            if (we !== 1'b1 || write_addr !== AW'(exp_a) || frame_done !== (exp_a == NPIX - 1)) begin
                miscompares++;
                $display("FAIL box_write: we=%b addr=%0d fd=%b, required we=1 addr=%0d fd=%b",
                         we, write_addr, frame_done, exp_a, (exp_a == NPIX - 1));
            end
            for (int k = 0; k < 6; k++) begin
                if (exp_a == pa[k]) begin
                    vectors++;
                    if (pixel !== pv[k]) begin
                        miscompares++;
                        $display("FAIL box_pixel: addr=%0d pixel=%b, required %b", exp_a, pixel, pv[k]);
                    end
                end
            end
            if (exp_a == 100) enable = 1'b0;
            exp_a++;
            if (exp_a < NPIX) @(negedge clk_25);
        end
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL busy_at_done: busy=%b, required 1", busy);
        end
        @(negedge clk_25);
        vectors++;
        if (busy !== 1'b0 || we !== 1'b0 || frame_done !== 1'b0) begin
            miscompares++;
            $display("FAIL after_done: busy=%b we=%b fd=%b, required 0 0 0", busy, we, frame_done);
        end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk_25);
            vectors++;
            if (we !== 1'b0) begin
                miscompares++;
                $display("FAIL idle_we: cycle %0d we=%b, required 0", c, we);
            end
        end
    endtask

    // Mode 1 -> 2 mid-frame: rest of frame stays box, next frame is checker
    task automatic test_mode_switch();
        int n = 0;
        int exp_a;
        bit ok = 0;
        int tf[7] = '{0, 0, 1, 1, 1, 1, 1};
        int ta[7] = '{5001, 6441, 0, 8, 1288, 2407, 6441};
        bit tv[7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        mode = 2'd1; enable = 1'b1;
        for (int c = 0; c < 10 && !ok; c++) begin
            @(negedge clk_25);
            ok = (we === 1'b1);
        end
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL switch_start: we=%b, required 1 within 10 cycles", we);
            return;
        end
        while (n < 2 * NPIX) begin
            exp_a = n % NPIX;
            vectors++;
            if (we !== 1'b1 || write_addr !== AW'(exp_a) || frame_done !== (exp_a == NPIX - 1)) begin
                miscompares++;
                $display("FAIL switch_write: frame %0d we=%b addr=%0d fd=%b, required we=1 addr=%0d fd=%b",
                         n / NPIX, we, write_addr, frame_done, exp_a, (exp_a == NPIX - 1));
            end
            for (int k = 0; k < 7; k++) begin
                if (tf[k] == n / NPIX && ta[k] == exp_a) begin
                    vectors++;
                    if (pixel !== tv[k]) begin
                        miscompares++;
                        $display("FAIL switch_pixel: frame %0d addr=%0d pixel=%b, required %b",
                                 tf[k], exp_a, pixel, tv[k]);
                    end
                end
            end
            if (n == 200) mode = 2'd2;
            if (n == NPIX + 300) enable = 1'b0;
            n++;
            if (n < 2 * NPIX) @(negedge clk_25);
        end
        repeat (2) @(negedge clk_25);
        vectors++;
        if (we !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL switch_end: we=%b busy=%b, required 0 0", we, busy);
        end
    endtask

    // Camera threshold with sparse strobes; threshold is garbage off-strobe
    task automatic test_camera();
        bit prev_v = 0;
        bit exp_p = 0;
        int k = 0;
        int exp_a = 0;
        mode = 2'd3; threshold = 8'h80; y_valid = 1'b0; y_in = 8'h00; enable = 1'b1;
        @(negedge clk_25);
        for (int i = 0; i < 60; i++) begin
            vectors++;
            if (we !== prev_v) begin
                miscompares++;
                $display("FAIL cam_we: step %0d we=%b, required %b", i, we, prev_v);
            end
            if (prev_v) begin
                vectors++;
                if (write_addr !== AW'(exp_a) || pixel !== exp_p) begin
                    miscompares++;
                    $display("FAIL cam_write: addr=%0d pixel=%b, required addr=%0d pixel=%b",
                             write_addr, pixel, exp_a, exp_p);
                end
                exp_a++;
            end else if (exp_a > 0) begin
                vectors++;
                if (write_addr !== AW'(exp_a - 1)) begin
                    miscompares++;
                    $display("FAIL cam_hold: addr=%0d, required %0d", write_addr, exp_a - 1);
                end
            end
            prev_v = (i % 3 == 0);
            if (i == 10) mode = 2'd0;
            if (prev_v) begin
                y_valid = 1'b1; threshold = 8'h80;
                y_in = k[0] ? 8'h80 : 8'h7F;
                exp_p = k[0];
                k++;
            end else begin
                y_valid = 1'b0; threshold = 8'hFF; y_in = 8'h80;
            end
            @(negedge clk_25);
        end
        enable = 1'b0; y_valid = 1'b0;
        reset_n = 1'b0;
        #1;
        vectors++;
        if (we !== 1'b0 || busy !== 1'b0 || write_addr !== '0 || pixel !== 1'b0 || frame_done !== 1'b0) begin
            miscompares++;
            $display("FAIL cam_abort: we=%b busy=%b addr=%0d pixel=%b fd=%b, required all 0",
                     we, busy, write_addr, pixel, frame_done);
        end
        @(negedge clk_25);
        reset_n = 1'b1;
        mode = 2'd0;
        @(negedge clk_25);
    endtask

    // Reset pulsed at address 5000, then restart from address 0
    task automatic test_reset_midframe();
        bit ok = 0;
        mode = 2'd0; enable = 1'b1;
        for (int c = 0; c < 6000 && !ok; c++) begin
            @(negedge clk_25);
            ok = (we === 1'b1 && write_addr === AW'(5000));
        end
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL rst_reach: addr=%0d, required 5000 within 6000 cycles", write_addr);
            return;
        end
        reset_n = 1'b0;
        #1;
        vectors++;
        if (we !== 1'b0 || busy !== 1'b0 || write_addr !== '0 || pixel !== 1'b0 || frame_done !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_async: we=%b busy=%b addr=%0d pixel=%b fd=%b, required all 0",
                     we, busy, write_addr, pixel, frame_done);
        end
        @(negedge clk_25);
        reset_n = 1'b1;
        ok = 0;
        for (int c = 0; c < 10 && !ok; c++) begin
            @(negedge clk_25);
            ok = (we === 1'b1);
        end
        vectors++;
        if (!ok || write_addr !== '0 || pixel !== 1'b1 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_restart: we=%b addr=%0d pixel=%b busy=%b, required 1 0 1 1",
                     we, write_addr, pixel, busy);
        end
        enable = 1'b0;
        reset_n = 1'b0;
        @(negedge clk_25);
        reset_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_box_frame();
        test_mode_switch();
        test_camera();
        test_reset_midframe();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
